// File: rtl/coin_payer.sv
// coin_payer: customer-side payer for the vending machine coin interface.
// Holds a wallet of half-yuan and one-yuan coins. On a buy request with
// sufficient funds it inserts coins one per cycle on `coin`, then waits for
// the machine's `drink`/`back` response, credits change to the half-yuan
// count and pulses `done` (or `fail` on short funds, early drink, timeout).
//
// Ports:
//   clk                   rising-edge clock
//   reset                 asynchronous active-low reset
//   load, half_in, one_in wallet load (IDLE only, wins over buy)
//   buy                   purchase request (IDLE only)
//   coin                  coin code: 0 none, 1 half-yuan, 2 one-yuan
//   drink, back           machine dispense pulse and change in half-yuan units
//   busy                  high while paying or waiting for the machine
//   done, fail            one-cycle completion pulses
//   change                `back` captured at the last successful purchase
//   half_left, one_left   current wallet counts
module coin_payer #(
  parameter int unsigned PRICE   = 3,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] half_in,
  input  logic [CNT_W-1:0] one_in,
  input  logic             buy,
  output logic [1:0]       coin,
  input  logic             drink,
  input  logic [1:0]       back,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       change,
  output logic [CNT_W-1:0] half_left,
  output logic [CNT_W-1:0] one_left
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PAY  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int unsigned   TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam int unsigned   FW      = CNT_W + 2;
  localparam logic [FW-1:0] PRICE_F = FW'(PRICE);
  localparam logic [2:0]    PRICE_R = 3'(PRICE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic [1:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [1:0]       change_q, change_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] one_q, one_d;

  logic [FW-1:0]    funds;
  logic [2:0]       rem_src;
  logic [1:0]       next_coin;
  logic [2:0]       rem_after;
  logic [CNT_W:0]   half_sum;
  logic [CNT_W-1:0] half_credit;

  function automatic logic [1:0] pick_coin(input logic [2:0]       rem,
                                           input logic [CNT_W-1:0] h,
                                           input logic [CNT_W-1:0] o);
    if (rem >= 3'd2 && o != '0) begin
      return 2'd2;
    end else if (h != '0) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

  // The first coin is issued on the buy edge itself, so the coin choice is
  // made from PRICE in IDLE and from the remaining amount in PAY. rem_q is
  // therefore the amount still owed after the coin currently on the bus.
  always_comb begin
    funds       = FW'(half_q) + FW'({one_q, 1'b0});
    rem_src     = (state_q == S_IDLE) ? PRICE_R : rem_q;
    next_coin   = pick_coin(rem_src, half_q, one_q);
    rem_after   = (rem_src > {1'b0, next_coin}) ? (rem_src - {1'b0, next_coin}) : 3'd0;
    half_sum    = {1'b0, half_q} + (CNT_W + 1)'(back);
    half_credit = half_sum[CNT_W] ? CNT_MAX : half_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wcnt_d   = wcnt_q;
    coin_d   = 2'd0;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    change_d = change_q;
    half_d   = half_q;
    one_d    = one_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          half_d = half_in;
          one_d  = one_in;
        end else if (buy) begin
          if (funds < PRICE_F) begin
            fail_d = 1'b1;
          end else begin
            coin_d  = next_coin;
            rem_d   = rem_after;
            state_d = S_PAY;
            if (next_coin == 2'd2) begin
              one_d = one_q - CNT_W'(1);
            end else begin
              half_d = half_q - CNT_W'(1);
            end
          end
        end
      end

      S_PAY: begin
        if (rem_q == 3'd0) begin
          // Edge ending the last coin: a same-cycle drink is accepted here.
          if (drink) begin
            change_d = back;
            half_d   = half_credit;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            wcnt_d  = '0;
            state_d = S_WAIT;
          end
        end else if (drink) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          coin_d = next_coin;
          rem_d  = rem_after;
          if (next_coin == 2'd2) begin
            one_d = one_q - CNT_W'(1);
          end else begin
            half_d = half_q - CNT_W'(1);
          end
        end
      end

      S_WAIT: begin
        if (drink) begin
          change_d = back;
          half_d   = half_credit;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (wcnt_q == T_LAST) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      wcnt_q   <= '0;
      coin_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      change_q <= '0;
      half_q   <= '0;
      one_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wcnt_q   <= wcnt_d;
      coin_q   <= coin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      change_q <= change_d;
      half_q   <= half_d;
      one_q    <= one_d;
    end
  end

  assign coin      = coin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign change    = change_q;
  assign half_left = half_q;
  assign one_left  = one_q;

endmodule

// File: tb/tb_coin_payer.sv
// Self-checking bench for coin_payer: a table of IDLE load/buy vectors,
// hand-written multi-cycle sequences, and randomized purchases checked
// against a transaction-level wallet/payment model.
module tb_coin_payer;
  localparam int PRICE   = 3;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load, buy, drink;
  logic [CNT_W-1:0] half_in, one_in;
  logic [1:0]       back;
  logic [1:0]       coin, change;
  logic             busy, done, fail;
  logic [CNT_W-1:0] half_left, one_left;

  int tests = 0;
  int fails = 0;
  int chg_exp = 0;

  always #5 clk = ~clk;

  coin_payer #(.PRICE(PRICE), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n), .load(load), .half_in(half_in), .one_in(one_in),
    .buy(buy), .coin(coin), .drink(drink), .back(back), .busy(busy),
    .done(done), .fail(fail), .change(change), .half_left(half_left),
    .one_left(one_left)
  );

  typedef struct {
    logic       ld;
    logic [3:0] h;
    logic [3:0] o;
    logic       by;
    logic       e_fail;
    logic [3:0] e_half;
    logic [3:0] e_one;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int o);
    load = 1'b1; half_in = 4'(h); one_in = 4'(o);
    cyc();
    load = 1'b0;
    chk("load_half", half_left, h);
    chk("load_one", one_left, o);
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs[7];
    int q[$];
    int h0, o0, h, o, h1, o1, paid, c, mode, r, j;
    bit early;

    hs = '{0, 1, 2, 3, 4, 14, 15};
    vt[0] = '{1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd1, 4'd0};
    vt[1] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1, 4'd0};
    vt[2] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd0};
    vt[3] = '{1'b1, 4'd5, 4'd3, 1'b1, 1'b0, 4'd5, 4'd3};
    vt[4] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd3};
    vt[5] = '{1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 4'd0, 4'd1};
    vt[6] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 4'd1};
    vt[7] = '{1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 4'd3, 4'd0};

    rst_n = 1'b0; load = 1'b0; buy = 1'b0; drink = 1'b0;
    half_in = '0; one_in = '0; back = '0;
    #12;
    chk("rst_coin", coin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_change", change, 0);
    chk("rst_half", half_left, 0);
    chk("rst_one", one_left, 0);
    rst_n = 1'b1;
    cyc();

    // IDLE load/buy table
    for (int i = 0; i < 8; i++) begin
      load = vt[i].ld; half_in = vt[i].h; one_in = vt[i].o; buy = vt[i].by;
      cyc();
      load = 1'b0; buy = 1'b0;
      chk("tbl_fail", fail, vt[i].e_fail);
      chk("tbl_busy", busy, 0);
      chk("tbl_coin", coin, 0);
      chk("tbl_half", half_left, vt[i].e_half);
      chk("tbl_one", one_left, vt[i].e_one);
    end

    // Exact pay
    do_load(2, 1);
    buy = 1'b1; cyc(); buy = 1'b0;
    chk("exact_c0", coin, 2); chk("exact_busy", busy, 1); chk("exact_one", one_left, 0);
    cyc();
    chk("exact_c1", coin, 1); chk("exact_half1", half_left, 1);
    cyc();
    chk("exact_c2", coin, 0); chk("exact_wbusy", busy, 1);
    drink = 1'b1; back = 2'd0; cyc(); drink = 1'b0;
    chk("exact_done", done, 1); chk("exact_busy0", busy, 0);
    chk("exact_change", change, 0); chk("exact_half", half_left, 1); chk("exact_one2", one_left, 0);
    cyc();
    chk("exact_done_pulse", done, 0);

    // Overpay
    do_load(0, 2);
    buy = 1'b1; cyc(); buy = 1'b0;
    chk("over_c0", coin, 2);
    cyc();
    chk("over_c1", coin, 2);
    cyc();
    chk("over_c2", coin, 0);
    drink = 1'b1; back = 2'd1; cyc(); drink = 1'b0; back = 2'd0;
    chk("over_done", done, 1); chk("over_change", change, 1);
    chk("over_half", half_left, 1); chk("over_one", one_left, 0);
    chg_exp = 1;
    cyc();

    // Timeout
    do_load(0, 2);
    buy = 1'b1; cyc(); buy = 1'b0;
    cyc(); cyc();
    chk("to_wait_coin", coin, 0);
    for (int w = 0; w < TIMEOUT - 1; w++) begin
      cyc();
      chk("to_nofail", fail, 0); chk("to_busy", busy, 1);
    end
    cyc();
    chk("to_fail", fail, 1); chk("to_busy0", busy, 0); chk("to_one", one_left, 0);
    chk("to_change", change, chg_exp);
    cyc();
    chk("to_fail_pulse", fail, 0); chk("to_idle", busy, 0);

    // Early drink
    do_load(0, 2);
    buy = 1'b1; cyc(); buy = 1'b0;
    chk("early_c0", coin, 2);
    drink = 1'b1; cyc(); drink = 1'b0;
    chk("early_fail", fail, 1); chk("early_coin", coin, 0);
    chk("early_busy", busy, 0); chk("early_one", one_left, 1);
    cyc();
    chk("early_idle", busy, 0);

    // Reset during PAY
    do_load(2, 1);
    buy = 1'b1; cyc(); buy = 1'b0;
    chk("rp_c0", coin, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rp_coin", coin, 0); chk("rp_busy", busy, 0); chk("rp_change", change, 0);
    chk("rp_half", half_left, 0); chk("rp_one", one_left, 0);
    #1 rst_n = 1'b1;
    chg_exp = 0;
    cyc();
    chk("rp_coin_after", coin, 0); chk("rp_busy_after", busy, 0);

    // Requests while busy are ignored
    do_load(2, 1);
    buy = 1'b1; cyc(); buy = 1'b0;
    chk("ib_c0", coin, 2);
    buy = 1'b1; load = 1'b1; half_in = 4'd9; one_in = 4'd9;
    cyc(); buy = 1'b0; load = 1'b0;
    chk("ib_c1", coin, 1); chk("ib_half", half_left, 1); chk("ib_one", one_left, 0);
    cyc();
    chk("ib_wait", busy, 1);
    buy = 1'b1; load = 1'b1;
    cyc(); buy = 1'b0; load = 1'b0;
    chk("ib_wait2", busy, 1); chk("ib_half2", half_left, 1);
    drink = 1'b1; back = 2'd2; cyc(); drink = 1'b0; back = 2'd0;
    chk("ib_done", done, 1); chk("ib_change", change, 2); chk("ib_half3", half_left, 3);
    chg_exp = 2;
    cyc();

    // Randomized purchases against a transaction-level model
    for (int t = 0; t < 60; t++) begin
      h0 = hs[$urandom_range(0, 6)];
      o0 = $urandom_range(0, 4);
      do_load(h0, o0);
      if (h0 + 2 * o0 < PRICE) begin
        buy = 1'b1; cyc(); buy = 1'b0;
        chk("rnd_short_fail", fail, 1); chk("rnd_short_busy", busy, 0);
        chk("rnd_short_coin", coin, 0);
        chk("rnd_short_half", half_left, h0); chk("rnd_short_one", one_left, o0);
        cyc();
        chk("rnd_short_pulse", fail, 0);
        continue;
      end
      q.delete();
      h = h0; o = o0; paid = 0; h1 = 0; o1 = 0;
      while (paid < PRICE) begin
        if (PRICE - paid >= 2 && o > 0) begin c = 2; o--; end
        else if (h > 0) begin c = 1; h--; end
        else begin c = 2; o--; end
        paid += c;
        q.push_back(c);
        if (q.size() == 1) begin h1 = h; o1 = o; end
      end
      mode = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      early = (mode == 1) && (q.size() >= 2);

      buy = 1'b1; cyc(); buy = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
        if (i > 0) cyc();
        chk("rnd_coin", coin, q[i]);
        chk("rnd_pay_busy", busy, 1);
        if (early) break;
      end

      if (early) begin
        drink = 1'b1; back = 2'(r); cyc(); drink = 1'b0;
        chk("rnd_early_fail", fail, 1); chk("rnd_early_coin", coin, 0);
        chk("rnd_early_busy", busy, 0); chk("rnd_early_change", change, chg_exp);
        chk("rnd_early_half", half_left, h1); chk("rnd_early_one", one_left, o1);
      end else if (mode == 2) begin
        drink = 1'b1; back = 2'(r); cyc(); drink = 1'b0;
        chg_exp = r;
        chk("rnd_mealy_done", done, 1); chk("rnd_mealy_coin", coin, 0);
        chk("rnd_mealy_busy", busy, 0); chk("rnd_mealy_change", change, chg_exp);
        chk("rnd_mealy_half", half_left, sat(h + r)); chk("rnd_mealy_one", one_left, o);
      end else begin
        cyc();
        chk("rnd_wait_coin", coin, 0); chk("rnd_wait_busy", busy, 1);
        j = (mode == 0) ? TIMEOUT : ((mode == 3) ? $urandom_range(0, TIMEOUT - 1) : 0);
        for (int w = 0; w < TIMEOUT; w++) begin
          if (w == j) begin
            drink = 1'b1; back = 2'(r); cyc(); drink = 1'b0;
            chg_exp = r;
            chk("rnd_done", done, 1); chk("rnd_done_busy", busy, 0);
            chk("rnd_change", change, chg_exp);
            chk("rnd_half", half_left, sat(h + r)); chk("rnd_one", one_left, o);
            break;
          end
          cyc();
          if (w == TIMEOUT - 1) begin
            chk("rnd_to_fail", fail, 1); chk("rnd_to_busy", busy, 0);
            chk("rnd_to_half", half_left, h); chk("rnd_to_one", one_left, o);
            chk("rnd_to_change", change, chg_exp);
          end else begin
            chk("rnd_wait_nofail", fail, 0); chk("rnd_wait_busy2", busy, 1);
          end
        end
      end
      back = 2'd0;
      cyc();
      chk("rnd_end_done", done, 0); chk("rnd_end_fail", fail, 0); chk("rnd_end_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
